// File: rtl/peri_pdm_rx_if.sv
// Wishbone B4 8-bit slave bus bundle for the PDM receiver peripheral.
// Latency: none; this file only groups the bus wires.
// Backpressure: none; ack is returned in the strobe cycle.
interface peri_pdm_rx_if;
  logic       wb_we_i;
  logic [3:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic       wb_stb_i;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o;

  modport master (
    output wb_we_i, wb_adr_i, wb_dat_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_we_i, wb_adr_i, wb_dat_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/peri_pdm_rx.sv
// PDM microphone receiver: drives pdm_clk_o, boxcar-decimates pdm_dat_i into 8-bit PCM samples.
// Latency: a sample is pushed on the edge its DECIM-th bit is taken; bus reads are combinational.
// Backpressure: none on the bus; a push into a full buffer is dropped and sets sticky overrun.
// Build option: PERI_PDM_RX_FIFO_EN selects a 4-entry FIFO instead of a single holding register.
module peri_pdm_rx #(
  parameter int CLK_DIV = 4,
  parameter int DECIM   = 256
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  peri_pdm_rx_if.slave wb,
  output logic         pdm_clk_o,
  input  logic         pdm_dat_i
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OW = $clog2(DECIM + 1);
  localparam int BW = $clog2(DECIM);

  logic [DW-1:0] div_q;
  logic          enable_q;
  logic          overrun_q;
  logic [OW-1:0] ones_q;
  logic [OW-1:0] ones_nxt;
  logic [BW-1:0] bits_q;
  logic          div_tc;
  logic          bit_stb;
  logic          last_bit;
  logic          push;
  logic          push_ok;
  logic          pop;
  logic          ovr_ev;
  logic          ctrl_wr;
  logic          rd_cyc;
  logic [8:0]    ones_ext;
  logic [7:0]    sample;
  logic          fifo_vld;
  logic          fifo_full;
  logic [7:0]    fifo_head;
  logic          unused_dat;

  // Bus decode: only CTRL bits 1 and 2 are meaningful on writes.
  assign rd_cyc     = wb.wb_stb_i & ~wb.wb_we_i;
  assign ctrl_wr    = wb.wb_stb_i & wb.wb_we_i & (wb.wb_adr_i == 4'd1);
  assign pop        = rd_cyc & (wb.wb_adr_i == 4'd0) & fifo_vld;
  assign unused_dat = ^{wb.wb_dat_i[7:3], wb.wb_dat_i[0]};

  // A bit is taken on the edge that ends the high phase of pdm_clk_o.
  assign div_tc   = (div_q == DW'(CLK_DIV - 1));
  assign bit_stb  = enable_q & div_tc & pdm_clk_o;
  assign last_bit = (bits_q == BW'(DECIM - 1));
  assign ones_nxt = ones_q + OW'(pdm_dat_i);

  // DECIM ones out of DECIM=256 bits would need 9 bits; saturate to the 8-bit range.
  assign ones_ext = 9'(ones_nxt);
  assign sample   = (ones_ext > 9'd255) ? 8'hFF : ones_ext[7:0];

  assign push    = bit_stb & last_bit;
  assign push_ok = push & (~fifo_full | pop);
  assign ovr_ev  = push & fifo_full & ~pop;

  // Divider and PDM clock: free-running only while enabled, parked low otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q     <= '0;
      pdm_clk_o <= 1'b0;
    end else if (!enable_q) begin
      div_q     <= '0;
      pdm_clk_o <= 1'b0;
    end else if (div_tc) begin
      div_q     <= '0;
      pdm_clk_o <= ~pdm_clk_o;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  // Boxcar accumulator: counts bits and ones, restarts after each full window or on disable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bits_q <= '0;
      ones_q <= '0;
    end else if (!enable_q) begin
      bits_q <= '0;
      ones_q <= '0;
    end else if (bit_stb) begin
      if (last_bit) begin
        bits_q <= '0;
        ones_q <= '0;
      end else begin
        bits_q <= bits_q + BW'(1);
        ones_q <= ones_nxt;
      end
    end
  end

  // Control register: enable follows CTRL writes; overrun is sticky, and a new drop beats a clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enable_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        enable_q <= wb.wb_dat_i[1];
      end
      if (ovr_ev) begin
        overrun_q <= 1'b1;
      end else if (ctrl_wr && wb.wb_dat_i[2]) begin
        overrun_q <= 1'b0;
      end
    end
  end

`ifdef PERI_PDM_RX_FIFO_EN
  logic [7:0] mem_q [4];
  logic [1:0] wr_ptr_q;
  logic [1:0] rd_ptr_q;
  logic [2:0] cnt_q;

  assign fifo_full = (cnt_q == 3'd4);
  assign fifo_vld  = (cnt_q != 3'd0);
  assign fifo_head = mem_q[rd_ptr_q];

  // Circular sample FIFO; a pop frees the slot a same-cycle push into a full FIFO needs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= sample;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      cnt_q <= cnt_q + 3'(push_ok) - 3'(pop);
    end
  end
`else
  logic [7:0] hold_q;
  logic       hold_vld_q;

  assign fifo_full = hold_vld_q;
  assign fifo_vld  = hold_vld_q;
  assign fifo_head = hold_q;

  // Single holding register; a push in the popping cycle replaces the entry being read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else if (push_ok) begin
      hold_q     <= sample;
      hold_vld_q <= 1'b1;
    end else if (pop) begin
      hold_vld_q <= 1'b0;
    end
  end
`endif

  // Read mux: DATA shows the oldest sample, CTRL shows status; everything else reads zero.
  always_comb begin
    wb.wb_dat_o = 8'h00;
    if (rd_cyc) begin
      case (wb.wb_adr_i)
        4'd0:    wb.wb_dat_o = fifo_vld ? fifo_head : 8'h00;
        4'd1:    wb.wb_dat_o = {5'b0, overrun_q, enable_q, fifo_vld};
        default: wb.wb_dat_o = 8'h00;
      endcase
    end
  end

  assign wb.wb_ack_o = wb.wb_stb_i;

endmodule

// File: doc/peri_pdm_rx.md
Name: peri_pdm_rx

Overview:
- Wishbone B4 PDM receiver peripheral: the input-side counterpart of the PDM output channel.
- Drives the clock for an external PDM microphone and samples its 1-bit data stream.
- Decimates the stream with a boxcar ones-counter into 8-bit PCM samples, buffered for CPU reads over the same 8-bit Wishbone slave bus as the other peripherals.

Parameters:
- CLK_DIV, 4, clk_i cycles per pdm_clk_o half-period (>=1); pdm_clk_o period = 2*CLK_DIV clk_i cycles.
- DECIM, 256, PDM bits accumulated per output sample (2..256).

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- wb_we_i  input  1  write enable
- wb_adr_i  input  4  register address
- wb_dat_i  input  8  write data
- wb_stb_i  input  1  strobe
- wb_dat_o  output  8  read data
- wb_ack_o  output  1  acknowledge
- pdm_clk_o  output  1  PDM clock to microphone
- pdm_dat_i  input  1  PDM data from microphone

Behaviour:
- Reset is asynchronous and active-low, on rst_ni. All state clears on reset: pdm_clk_o=0, enable=0, overrun=0, FIFO empty, divider=0, counters=0.
- Wishbone outputs:
  - wb_ack_o = wb_stb_i, combinational, zero wait states.
  - wb_dat_o is combinational from the current address: 0 when no strobe, 0 on writes.
- Register map:
  - adr 0 (DATA), read: oldest FIFO entry. A read with FIFO non-empty pops one entry in that cycle. A read when empty returns 0x00 and has no side effect. Writes ignored.
  - adr 1 (CTRL), read: {5'b0, overrun, enable, valid}; valid = FIFO non-empty.
  - adr 1 (CTRL), write: bit1 -> enable; bit2=1 clears overrun; other bits ignored.
  - All other addresses: read 0x00, writes ignored.
- Clock generation:
  - While enable=1, the divider counts 0..CLK_DIV-1 and toggles pdm_clk_o at terminal count.
  - While enable=0: divider and pdm_clk_o held 0, ones-counter and bit-counter cleared, FIFO contents and overrun retained.
- Sampling:
  - pdm_dat_i is registered on the clk_i edge at which pdm_clk_o goes 1->0 (end of high phase).
  - Each sampled bit increments bitcnt and adds the bit to onescnt.
  - onescnt is clog2(DECIM+1) bits wide.
- Decimation:
  - When the DECIM-th bit is sampled: sample = min(onescnt_including_this_bit, 255).
  - The sample is pushed into the FIFO on that same edge, and onescnt and bitcnt clear on that same edge.
  - First sample is pushed DECIM*2*CLK_DIV clk_i cycles after enable rises.
- FIFO:
  - Push when full: the new sample is dropped, overrun set to 1 (sticky), contents unchanged.
  - Push and pop in the same cycle when full: both succeed, no overrun. When empty: the pop has no effect and the push succeeds.
  - Write-1 to clear overrun in the same cycle as an overrun event: overrun stays 1.
- Mid-operation disable: a partial accumulation is discarded, with no push.

Optional Feature:
- Macro: PERI_PDM_RX_FIFO_EN.
  - Defined: 4-entry circular FIFO with 2-bit read/write pointers and a 3-bit count.
  - Undefined: single holding register with valid flag (depth 1); all push/pop/overrun rules identical with depth 1.

Test Plan:
- Reset defaults: reset mid-run -> pdm_clk_o=0 immediately; CTRL reads 0x00; DATA reads 0x00.
- Constant-ones: CLK_DIV=2, DECIM=256, enable, pdm_dat_i=1 -> pdm_clk_o period 4 cycles; after 1024 cycles valid=1; DATA=0xFF (saturated from 256); valid then 0.
- Half-density: CLK_DIV=1, DECIM=16, pdm_dat_i alternating 1/0 per PDM bit -> each sample 0x08.
- Constant-zeros: CLK_DIV=1, DECIM=16, pdm_dat_i=0 -> each sample 0x00.
- Overrun:
  - Stimulus: DECIM=16, no reads for 6 sample periods.
  - Required response with FIFO_EN: reads return 4 samples then empty; overrun=1.
  - Required response without FIFO_EN: one sample; overrun=1.
  - CTRL write 0x06 -> overrun=0, enable stays 1.
- Disable mid-sample: disable after 10 of 16 bits, re-enable -> next sample reflects only the 16 new bits; buffered samples intact.
